aes_128_keyram_ctrl: RTL and testbench
======================================

// Module: aes_128_keyram_ctrl
// PURPOSE
//  Controller for the AES-128 round-key RAM (16x128, write port + sequential key_ready read).
//  - Loads NR+1 round keys from the key-expansion engine into RAM addresses 0..NR.
//  - Sequences one key_ready pulse per cipher round for the 3-cycle-round datapath.
//  - Serialises load vs. run: only one may be active at a time.
// PARAMETERS
//  NR         10  number of AES rounds; NR+1 keys are stored and read (NR+1 <= 16)
//  ROUND_CYC   3  clocks per cipher round = spacing between key_ready pulses (>= 2)
// PORTS
//  clk          in    1    clock; all logic on rising edge
//  kill         in    1    asynchronous reset, active-low
//  load_start   in    1    pulse: begin new key load; invalidates stored keys
//  kx_valid     in    1    expansion engine presents a round key
//  kx_key       in  128    round key from expansion engine
//  kx_ready     out   1    controller accepts kx_key this cycle
//  run_start    in    1    pulse: begin one block encryption
//  keys_valid   out   1    all NR+1 keys stored
//  busy         out   1    state != IDLE
//  round_idx    out   4    index of the key most recently issued
//  last_round   out   1    high with the key_ready pulse for key NR
//  run_done     out   1    1-cycle pulse at end of run
//  rd_rewind    out   1    1-cycle pulse; restarts keyram read pointer to address 0
//  en_wr        out   1    keyram write enable
//  addr_wr      out   4    keyram write address
//  key_round_wr out 128    keyram write data
//  key_ready    out   1    keyram read-advance pulse
// BEHAVIOUR
//  Reset (kill=0): state=IDLE; wr_ptr=0; all outputs 0 (keys_valid=0, key_round_wr=0).
//  FSM states: IDLE, LOAD, RUN.
//  IDLE:
//   - load_start -> LOAD; wr_ptr=0; keys_valid=0.
//   - run_start with keys_valid=1 -> RUN.
//   - Both asserted in the same cycle: load_start wins; run_start is dropped.
//  LOAD:
//   - kx_ready=1 throughout. Each kx_valid&kx_ready registers en_wr=1, addr_wr=wr_ptr,
//     key_round_wr=kx_key in the next cycle (latency 1); wr_ptr++.
//   - en_wr is high exactly 1 cycle per accepted key; no back-to-back gaps are required.
//   - Write NR (wr_ptr==NR): keys_valid=1 in the same cycle as that en_wr; -> IDLE.
//   - load_start in LOAD restarts: wr_ptr=0; any write already registered still completes.
//  RUN:
//   - Cycle after run_start: rd_rewind=1. Next cycle: first key_ready, round_idx=0.
//   - Key k (k=0..NR): key_ready pulse at rewind+1+k*ROUND_CYC; round_idx=k is held
//     until the next pulse.
//   - last_round=1 only with the pulse for k=NR.
//   - run_done pulses ROUND_CYC cycles after the last key_ready; -> IDLE in the same cycle.
//   - Exactly NR+1 key_ready pulses per run.
//  Outside LOAD: kx_ready=0 and kx_valid is ignored.
//  Requests while busy: load_start in RUN is ignored (no queueing); run_start in LOAD/RUN,
//  or in IDLE with keys_valid=0, is ignored.
//  Counters: wr_ptr and the round counter are 4-bit, never wrap past NR, and are cleared on
//  the next start.
//  Reset mid-LOAD or mid-RUN: immediate IDLE; keys_valid=0; no further en_wr or key_ready.
// CONFIGURATION
//  Macro KEYRAM_CTRL_ERR_EN:
//   - Defined: adds output err (1 bit), sticky, cleared only by kill. err is set by any
//     ignored request: load_start in RUN, run_start while busy or with keys_valid=0,
//     or kx_valid outside LOAD.
//   - Undefined: no err port; those requests are silently ignored. All other behaviour
//     is identical.
// TESTING
//  T1 Reset: kill low 50 ns -> all outputs 0, busy=0, keys_valid=0.
//  T2 Load: load_start, then 11 kx_valid beats with keys 0x00..0x0A ->
//     addr_wr 0..10 with matching data; keys_valid rises with addr 10; kx_ready drops.
//  T3 Run: run_start -> rd_rewind at +1; key_ready at +2,+5,...,+32 (11 pulses);
//     last_round at +32; run_done at +35.
//  T4 Conflict: load_start during RUN -> run completes normally and keys_valid stays 1;
//     with KEYRAM_CTRL_ERR_EN, err=1.
//  T5 Restart mid-load: after 5 keys, load_start -> next key is written at addr 0;
//     keys_valid only after 11 further keys.
//  T6 Reset mid-run: kill after the 4th key_ready -> no further key_ready or run_done;
//     keys_valid=0; a subsequent run_start is ignored.

Source files
------------

// File: rtl/aes_128_keyram_ctrl.sv
// Round-key RAM controller for AES-128: loads NR+1 expanded keys, then paces key_ready per round.
// Define KEYRAM_CTRL_ERR_EN to add a sticky err output flagging ignored requests.
module aes_128_keyram_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_CYC = 3
) (
    input  logic         clk,
    input  logic         kill,
    input  logic         load_start,
    input  logic         kx_valid,
    input  logic [127:0] kx_key,
    output logic         kx_ready,
    input  logic         run_start,
    output logic         keys_valid,
    output logic         busy,
    output logic [3:0]   round_idx,
    output logic         last_round,
    output logic         run_done,
    output logic         rd_rewind,
    output logic         en_wr,
    output logic [3:0]   addr_wr,
    output logic [127:0] key_round_wr,
    output logic         key_ready
`ifdef KEYRAM_CTRL_ERR_EN
    ,
    output logic         err
`endif
);

    localparam int              CW         = $clog2(ROUND_CYC);
    localparam logic [3:0]      LAST_KEY   = 4'(NR);
    localparam logic [CW-1:0]   CYC_RELOAD = CW'(ROUND_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t         state, state_nxt;
    logic [3:0]     wr_ptr, wr_ptr_nxt;
    logic [3:0]     wr_addr;
    logic [3:0]     rnd_cnt, rnd_cnt_nxt;
    logic [CW-1:0]  cyc_cnt, cyc_cnt_nxt;
    logic           issued_all, issued_all_nxt;
    logic           accept;
    logic           keys_valid_nxt, en_wr_nxt, rd_rewind_nxt;
    logic           key_ready_nxt, last_round_nxt, run_done_nxt;
    logic [3:0]     addr_wr_nxt, round_idx_nxt;
    logic [127:0]   key_round_wr_nxt;

    assign kx_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign accept   = kx_valid && kx_ready;
    // A beat arriving together with a restart becomes key 0 of the new load.
    assign wr_addr  = load_start ? 4'd0 : wr_ptr;

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end else if (run_start && keys_valid) begin
                    state_nxt = RUN;
                end
            end
            LOAD: begin
                if (accept && wr_addr == LAST_KEY) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cyc_cnt == '0 && issued_all) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_nxt       = wr_ptr;
        rnd_cnt_nxt      = rnd_cnt;
        cyc_cnt_nxt      = cyc_cnt;
        issued_all_nxt   = issued_all;
        keys_valid_nxt   = keys_valid;
        addr_wr_nxt      = addr_wr;
        key_round_wr_nxt = key_round_wr;
        round_idx_nxt    = round_idx;
        en_wr_nxt        = 1'b0;
        rd_rewind_nxt    = 1'b0;
        key_ready_nxt    = 1'b0;
        last_round_nxt   = 1'b0;
        run_done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    wr_ptr_nxt     = 4'd0;
                    keys_valid_nxt = 1'b0;
                end else if (run_start && keys_valid) begin
                    rd_rewind_nxt  = 1'b1;
                    cyc_cnt_nxt    = '0;
                    rnd_cnt_nxt    = 4'd0;
                    issued_all_nxt = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wr_ptr_nxt = 4'd0;
                end
                if (accept) begin
                    en_wr_nxt        = 1'b1;
                    addr_wr_nxt      = wr_addr;
                    key_round_wr_nxt = kx_key;
                    if (wr_addr == LAST_KEY) begin
                        keys_valid_nxt = 1'b1;
                        wr_ptr_nxt     = wr_addr;
                    end else begin
                        wr_ptr_nxt = wr_addr + 4'd1;
                    end
                end
            end
            RUN: begin
                // cyc_cnt counts down the gap to the next key_ready; zero means act this edge.
                if (cyc_cnt == '0) begin
                    if (issued_all) begin
                        run_done_nxt = 1'b1;
                    end else begin
                        key_ready_nxt  = 1'b1;
                        round_idx_nxt  = rnd_cnt;
                        last_round_nxt = (rnd_cnt == LAST_KEY);
                        cyc_cnt_nxt    = CYC_RELOAD;
                        if (rnd_cnt == LAST_KEY) begin
                            issued_all_nxt = 1'b1;
                        end else begin
                            rnd_cnt_nxt = rnd_cnt + 4'd1;
                        end
                    end
                end else begin
                    cyc_cnt_nxt = cyc_cnt - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            wr_ptr       <= 4'd0;
            rnd_cnt      <= 4'd0;
            cyc_cnt      <= '0;
            issued_all   <= 1'b0;
            keys_valid   <= 1'b0;
            addr_wr      <= 4'd0;
            key_round_wr <= '0;
            round_idx    <= 4'd0;
            en_wr        <= 1'b0;
            rd_rewind    <= 1'b0;
            key_ready    <= 1'b0;
            last_round   <= 1'b0;
            run_done     <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rnd_cnt      <= rnd_cnt_nxt;
            cyc_cnt      <= cyc_cnt_nxt;
            issued_all   <= issued_all_nxt;
            keys_valid   <= keys_valid_nxt;
            addr_wr      <= addr_wr_nxt;
            key_round_wr <= key_round_wr_nxt;
            round_idx    <= round_idx_nxt;
            en_wr        <= en_wr_nxt;
            rd_rewind    <= rd_rewind_nxt;
            key_ready    <= key_ready_nxt;
            last_round   <= last_round_nxt;
            run_done     <= run_done_nxt;
        end
    end

`ifdef KEYRAM_CTRL_ERR_EN
    logic ignored;

    assign ignored = (load_start && state == RUN)
                  || (run_start && (state != IDLE || !keys_valid))
                  || (kx_valid && state != LOAD);

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            err <= 1'b0;
        end else if (ignored) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_128_keyram_ctrl.sv
// Self-checking bench for aes_128_keyram_ctrl: random key loads and runs checked against
// pulse timing derived arithmetically from NR and ROUND_CYC.
module tb_aes_128_keyram_ctrl;

    localparam int NR = 10;
    localparam int RC = 3;

    logic         clk = 1'b0;
    logic         kill;
    logic         load_start;
    logic         kx_valid;
    logic [127:0] kx_key;
    logic         kx_ready;
    logic         run_start;
    logic         keys_valid;
    logic         busy;
    logic [3:0]   round_idx;
    logic         last_round;
    logic         run_done;
    logic         rd_rewind;
    logic         en_wr;
    logic [3:0]   addr_wr;
    logic [127:0] key_round_wr;
    logic         key_ready;
`ifdef KEYRAM_CTRL_ERR_EN
    logic         err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [3:0] rid_model = 4'd0;

    always #5 clk = ~clk;

    aes_128_keyram_ctrl #(.NR(NR), .ROUND_CYC(RC)) dut (
        .clk          (clk),
        .kill         (kill),
        .load_start   (load_start),
        .kx_valid     (kx_valid),
        .kx_key       (kx_key),
        .kx_ready     (kx_ready),
        .run_start    (run_start),
        .keys_valid   (keys_valid),
        .busy         (busy),
        .round_idx    (round_idx),
        .last_round   (last_round),
        .run_done     (run_done),
        .rd_rewind    (rd_rewind),
        .en_wr        (en_wr),
        .addr_wr      (addr_wr),
        .key_round_wr (key_round_wr),
        .key_ready    (key_ready)
`ifdef KEYRAM_CTRL_ERR_EN
        ,
        .err          (err)
`endif
    );

    function automatic logic [127:0] randKey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 ns after an edge and outputs are sampled 1 ns after the next one.
    task automatic applyStimulus(input logic ls, input logic rs, input logic kv, input logic [127:0] key);
        load_start = ls;
        run_start  = rs;
        kx_valid   = kv;
        kx_key     = key;
        @(posedge clk);
        #1;
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_kx_ready"},   128'(kx_ready),   128'(0));
        checkOutput({tag, "_keys_valid"}, 128'(keys_valid), 128'(0));
        checkOutput({tag, "_busy"},       128'(busy),       128'(0));
        checkOutput({tag, "_round_idx"},  128'(round_idx),  128'(0));
        checkOutput({tag, "_last_round"}, 128'(last_round), 128'(0));
        checkOutput({tag, "_run_done"},   128'(run_done),   128'(0));
        checkOutput({tag, "_rd_rewind"},  128'(rd_rewind),  128'(0));
        checkOutput({tag, "_en_wr"},      128'(en_wr),      128'(0));
        checkOutput({tag, "_addr_wr"},    128'(addr_wr),    128'(0));
        checkOutput({tag, "_wr_data"},    key_round_wr,     128'(0));
        checkOutput({tag, "_key_ready"},  128'(key_ready),  128'(0));
    endtask

    task automatic startLoad();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("load_busy",       128'(busy),       128'(1));
        checkOutput("load_kx_ready",   128'(kx_ready),   128'(1));
        checkOutput("load_keys_valid", 128'(keys_valid), 128'(0));
        checkOutput("load_en_wr",      128'(en_wr),      128'(0));
    endtask

    task automatic loadBeats(input int n, input bit seq_keys);
        logic [127:0] key;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                applyStimulus(1'b0, 1'b0, 1'b0, randKey());
                checkOutput("gap_en_wr",    128'(en_wr),    128'(0));
                checkOutput("gap_kx_ready", 128'(kx_ready), 128'(1));
            end
            key = seq_keys ? 128'(i) : randKey();
            applyStimulus(1'b0, 1'b0, 1'b1, key);
            checkOutput("wr_en",         128'(en_wr),      128'(1));
            checkOutput("wr_addr",       128'(addr_wr),    128'(i));
            checkOutput("wr_data",       key_round_wr,     key);
            checkOutput("wr_keys_valid", 128'(keys_valid), 128'(i == NR));
            checkOutput("wr_kx_ready",   128'(kx_ready),   128'(i != NR));
        end
    endtask

    // Key k pulses at run_start+2+k*RC; run_done follows RC cycles after key NR.
    task automatic runBlock(input int kill_after, input bit junk);
        int   ndone;
        int   pulses;
        int   k;
        logic exp_kr;
        logic ls, rs, kv;
        bit   killed;
        ndone  = 2 + (NR + 1) * RC;
        pulses = 0;
        killed = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int n = 1; n <= ndone + 2 && !killed; n++) begin
            k      = (n - 2) / RC;
            exp_kr = (n >= 2) && ((n - 2) % RC == 0) && (k <= NR);
            if (exp_kr) begin
                rid_model = 4'(k);
            end
            checkOutput("run_rd_rewind",  128'(rd_rewind),  128'(n == 1));
            checkOutput("run_key_ready",  128'(key_ready),  128'(exp_kr));
            checkOutput("run_last_round", 128'(last_round), 128'(exp_kr && k == NR));
            checkOutput("run_round_idx",  128'(round_idx),  128'(rid_model));
            checkOutput("run_run_done",   128'(run_done),   128'(n == ndone));
            checkOutput("run_busy",       128'(busy),       128'(n < ndone));
            checkOutput("run_en_wr",      128'(en_wr),      128'(0));
            checkOutput("run_keys_valid", 128'(keys_valid), 128'(1));
            checkOutput("run_kx_ready",   128'(kx_ready),   128'(0));
            if (key_ready) begin
                pulses++;
            end
            if (kill_after > 0 && pulses == kill_after) begin
                kill = 1'b0;
                #2;
                resetChecks("midrun");
                #48;
                kill = 1'b1;
                rid_model = 4'd0;
                killed = 1'b1;
            end else begin
                ls = junk && n < ndone && ($urandom_range(0, 3) == 0 || n == 5);
                rs = junk && n < ndone && ($urandom_range(0, 3) == 0);
                kv = junk && n < ndone && ($urandom_range(0, 3) == 0);
                applyStimulus(ls, rs, kv, randKey());
            end
        end
        if (!killed) begin
            checkOutput("run_pulse_count", 128'(pulses), 128'(NR + 1));
        end
    endtask

    initial begin
        kill       = 1'b0;
        load_start = 1'b0;
        run_start  = 1'b0;
        kx_valid   = 1'b0;
        kx_key     = '0;
        #50;
        resetChecks("reset");
        kill = 1'b1;
        @(posedge clk);
        #1;
`ifdef KEYRAM_CTRL_ERR_EN
        checkOutput("err_after_reset", 128'(err), 128'(0));
`endif

        $display("[TB] load with sequential keys");
        startLoad();
        loadBeats(NR + 1, 1'b1);
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0);
            checkOutput("idle_busy",       128'(busy),       128'(0));
            checkOutput("idle_keys_valid", 128'(keys_valid), 128'(1));
            checkOutput("idle_en_wr",      128'(en_wr),      128'(0));
        end

        $display("[TB] clean run");
        runBlock(0, 1'b0);
`ifdef KEYRAM_CTRL_ERR_EN
        checkOutput("err_clean", 128'(err), 128'(0));
`endif

        $display("[TB] random load and run iterations");
        for (int it = 0; it < 3; it++) begin
            startLoad();
            loadBeats(NR + 1, 1'b0);
            repeat ($urandom_range(0, 4)) applyStimulus(1'b0, 1'b0, 1'b0, '0);
            runBlock(0, 1'b0);
        end

        $display("[TB] requests during run are ignored");
        runBlock(0, 1'b1);
        checkOutput("conflict_keys_valid", 128'(keys_valid), 128'(1));
`ifdef KEYRAM_CTRL_ERR_EN
        checkOutput("err_conflict", 128'(err), 128'(1));
`endif

        $display("[TB] simultaneous load and run, then restart mid-load");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("both_busy",       128'(busy),       128'(1));
        checkOutput("both_kx_ready",   128'(kx_ready),   128'(1));
        checkOutput("both_keys_valid", 128'(keys_valid), 128'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("both_no_rewind",  128'(rd_rewind),  128'(0));
        loadBeats(5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("restart_en_wr",      128'(en_wr),      128'(0));
        checkOutput("restart_busy",       128'(busy),       128'(1));
        checkOutput("restart_keys_valid", 128'(keys_valid), 128'(0));
        loadBeats(NR + 1, 1'b0);
        runBlock(0, 1'b0);

        $display("[TB] reset in the middle of a run");
        runBlock(4, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int n = 0; n < 40; n++) begin
            checkOutput("post_kill_key_ready",  128'(key_ready),  128'(0));
            checkOutput("post_kill_run_done",   128'(run_done),   128'(0));
            checkOutput("post_kill_rd_rewind",  128'(rd_rewind),  128'(0));
            checkOutput("post_kill_busy",       128'(busy),       128'(0));
            checkOutput("post_kill_keys_valid", 128'(keys_valid), 128'(0));
            applyStimulus(1'b0, 1'b0, 1'b0, '0);
        end
`ifdef KEYRAM_CTRL_ERR_EN
        checkOutput("err_run_without_keys", 128'(err), 128'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
